// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one CPU load/store at a time onto a
// single-port data bus with waitrequest; stalls the CPU meanwhile.
// Ports: clk, reset (async, active-high); req_valid/write/size/
//   addr/wdata from the load/store unit; stall, rsp_valid,
//   rsp_rdata, rsp_err back to it; mem_* to the data RAM port.
// Params: TIMEOUT (wait cycles per bus phase, 0 = no watchdog),
//   CNT_W (watchdog counter width).
// Option: BYTE_ENABLE_EN -- sub-word stores use lane byteenables
//   instead of read-modify-write.
module mem_access_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byteenable,
  output logic [31:0] mem_writedata,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata
);

  typedef enum logic [1:0] {
    IDLE, READ, WRITE, DONE
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q;
  logic [1:0]       size_q;
  logic             write_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt;
`ifdef BYTE_ENABLE_EN
  logic [3:0]       be_q;
`endif

  logic misaligned;
  logic sub_word;
  logic tmo_hit;

  assign misaligned =
    (req_size == 2'd1 && req_addr[0]) ||
    (req_size[1] && req_addr[1:0] != 2'b00);
  assign sub_word = ~req_size[1];
  // Fires on the wait cycle that brings the count up to TIMEOUT.
  assign tmo_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [1:0]  off,
    input logic [1:0]  sz,
    input logic [31:0] d
  );
    logic [31:0] m;
    m = old;
    if (sz == 2'd0)
      m[{off, 3'b000} +: 8] = d[7:0];
    else
      m[{off[1], 4'b0000} +: 16] = d[15:0];
    return m;
  endfunction

`ifdef BYTE_ENABLE_EN
  function automatic logic [3:0] lanes(
    input logic [1:0] off,
    input logic [1:0] sz
  );
    unique case (1'b1)
      sz == 2'd0: lanes = 4'b0001 << off;
      sz == 2'd1: lanes = off[1] ? 4'b1100 : 4'b0011;
      default:    lanes = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] repl(
    input logic [31:0] d,
    input logic [1:0]  sz
  );
    unique case (1'b1)
      sz == 2'd0: repl = {4{d[7:0]}};
      sz == 2'd1: repl = {2{d[15:0]}};
      default:    repl = d;
    endcase
  endfunction
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      cnt     <= '0;
`ifdef BYTE_ENABLE_EN
      be_q    <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            size_q  <= req_size;
            write_q <= req_write;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt     <= '0;
`ifdef BYTE_ENABLE_EN
            wdata_q <= repl(req_wdata, req_size);
            be_q    <= lanes(req_addr[1:0], req_size);
            if (misaligned) begin
              err_q <= 1'b1;
              state <= DONE;
            end else if (req_write)
              state <= WRITE;
            else
              state <= READ;
`else
            wdata_q <= req_wdata;
            if (misaligned) begin
              err_q <= 1'b1;
              state <= DONE;
            end else if (req_write && !sub_word)
              state <= WRITE;
            else
              state <= READ;
`endif
          end
        end
        READ: begin
          if (mem_waitrequest) begin
            if (tmo_hit) begin
              err_q <= 1'b1;
              state <= DONE;
            end else
              cnt <= cnt + 1'b1;
          end else if (write_q) begin
            wdata_q <= merge(mem_readdata,
                             addr_q[1:0],
                             size_q, wdata_q);
            cnt     <= '0;
            state   <= WRITE;
          end else begin
            rdata_q <= mem_readdata;
            state   <= DONE;
          end
        end
        WRITE: begin
          if (mem_waitrequest) begin
            if (tmo_hit) begin
              err_q <= 1'b1;
              state <= DONE;
            end else
              cnt <= cnt + 1'b1;
          end else
            state <= DONE;
        end
        DONE: state <= IDLE;
      endcase
    end
  end

  logic on_bus;
  assign on_bus = (state == READ) || (state == WRITE);

  assign stall = (state == IDLE && req_valid) || on_bus;
  assign mem_read  = (state == READ);
  assign mem_write = (state == WRITE);
  assign mem_address =
    on_bus ? {addr_q[31:2], 2'b00} : 32'h0;
`ifdef BYTE_ENABLE_EN
  assign mem_byteenable =
    (state == READ)  ? 4'hF :
    (state == WRITE) ? be_q : 4'h0;
`else
  assign mem_byteenable = on_bus ? 4'hF : 4'h0;
`endif
  assign mem_writedata =
    (state == WRITE) ? wdata_q : 32'h0;
  assign rsp_valid = (state == DONE);
  assign rsp_rdata = (state == DONE) ? rdata_q : 32'h0;
  assign rsp_err   = (state == DONE) && err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed bench with a transaction-level
// model that expands each access into expected per-cycle outputs.
module tb_mem_access_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;

  mem_access_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr),
    .req_wdata(req_wdata), .stall(stall),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_address(mem_address),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_byteenable(mem_byteenable),
    .mem_writedata(mem_writedata),
    .mem_waitrequest(mem_waitrequest),
    .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rv;
    logic        wt;
    logic        stall;
    logic        rspv;
    logic        err;
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
  } cyc_t;

  int   n_pass = 0;
  int   n_total = 0;
  cyc_t exp_c;
  bit   exp_on = 0;
  int   cyc_no = 0;

  logic [31:0] last_wd;
  logic [3:0]  last_be;
  logic [31:0] last_rdata;
  int          hold1004;

  task automatic chk(string nm, logic [31:0] g,
                     logic [31:0] e);
    n_total++;
    if (g === e) n_pass++;
    else $display("FAIL %s got=%h want=%h", nm, g, e);
  endtask

  // Single compare process for every modelled cycle.
  always @(negedge clk) begin
    logic [104:0] got, want;
    if (exp_on) begin
      got = {stall, rsp_valid, rsp_err, mem_read,
             mem_write, mem_byteenable, mem_address,
             mem_writedata, rsp_rdata};
      want = {exp_c.stall, exp_c.rspv, exp_c.err,
              exp_c.rd, exp_c.wr, exp_c.be, exp_c.addr,
              exp_c.wd, exp_c.rdata};
      n_total++;
      if (got === want) n_pass++;
      else $display("FAIL cycle%0d got=%h want=%h",
                    cyc_no, got, want);
      if (mem_write) begin
        last_wd = mem_writedata;
        last_be = mem_byteenable;
      end
      if (mem_read && mem_address == 32'h1004)
        hold1004++;
      if (rsp_valid) last_rdata = rsp_rdata;
    end
  end

  // Model: expand one access into its expected cycle trace,
  // then drive it cycle by cycle.
  task automatic run(bit w, bit [1:0] sz, bit [31:0] a,
                     bit [31:0] d, bit [31:0] mw,
                     int rw, int ww);
    cyc_t q[$];
    cyc_t c;
    logic [7:0] b[4];
    bit mis, sub, need_rd, need_wr, tmo;
    bit [31:0] wa, wdat;
    bit [3:0] wbe;
    int off;
    off = a % 4;
    wa  = a - off;
    mis = (sz == 1 && off % 2 != 0) ||
          (sz >= 2 && off != 0);
    sub = sz < 2;
    for (int i = 0; i < 4; i++) b[i] = mw[8*i +: 8];
    if (sz == 0) b[off] = d[7:0];
    if (sz == 1) begin
      b[off]   = d[7:0];
      b[off+1] = d[15:8];
    end
`ifdef BYTE_ENABLE_EN
    need_rd = !mis && !w;
    wbe  = 4'hF;
    wdat = d;
    if (sz == 0) begin
      wbe  = 4'(1 << off);
      wdat = {4{d[7:0]}};
    end
    if (sz == 1) begin
      wbe  = (off == 2) ? 4'b1100 : 4'b0011;
      wdat = {2{d[15:0]}};
    end
`else
    need_rd = !mis && (!w || sub);
    wbe  = 4'hF;
    wdat = sub ? {b[3], b[2], b[1], b[0]} : d;
`endif
    need_wr = !mis && w;
    tmo = 0;
    c = '0; c.rv = 1; c.stall = 1;
    q.push_back(c);
    if (need_rd) begin
      for (int i = 0; i < TO; i++) begin
        c = '0; c.stall = 1; c.rd = 1;
        c.be = 4'hF; c.addr = wa; c.wt = (i < rw);
        q.push_back(c);
        if (!c.wt) break;
      end
      tmo = (rw >= TO);
    end
    if (need_wr && !tmo) begin
      for (int i = 0; i < TO; i++) begin
        c = '0; c.stall = 1; c.wr = 1; c.be = wbe;
        c.addr = wa; c.wd = wdat; c.wt = (i < ww);
        q.push_back(c);
        if (!c.wt) break;
      end
      tmo = (ww >= TO);
    end
    c = '0; c.rspv = 1; c.err = mis || tmo;
    c.rdata = (!w && !c.err) ? mw : 32'h0;
    q.push_back(c);
    c = '0;
    q.push_back(c);
    foreach (q[i]) begin
      @(posedge clk); #1;
      exp_c = q[i];
      cyc_no = i;
      req_valid = q[i].rv;
      mem_waitrequest = q[i].wt;
      mem_readdata = mw;
      // req_* must be ignored once the access is latched
      req_write = (i == 0) ? w : ~w;
      req_size  = (i == 0) ? sz : ~sz;
      req_addr  = (i == 0) ? a : ~a;
      req_wdata = (i == 0) ? d : ~d;
      exp_on = 1;
    end
    @(posedge clk); #1;
    exp_on = 0;
  endtask

  initial begin
    reset = 1;
    req_valid = 0; req_write = 0; req_size = 0;
    req_addr = 0; req_wdata = 0;
    mem_waitrequest = 0; mem_readdata = 0;
    #1;
    chk("rst_outs",
        {26'h0, stall, rsp_valid, rsp_err, mem_read,
         mem_write, |mem_byteenable},
        32'h0);
    chk("rst_addr", mem_address, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 0;

    hold1004 = 0;
    run(0, 2, 32'h0000_1004, 32'h0, 32'hDEADBEEF, 2, 0);
    chk("lw_hold", 32'(hold1004), 32'd3);
    chk("lw_rdata", last_rdata, 32'hDEADBEEF);

    run(1, 0, 32'h0000_2001, 32'hAB, 32'h11223344, 0, 0);
`ifdef BYTE_ENABLE_EN
    chk("sb_wd", last_wd, 32'hABABABAB);
    chk("sb_be", 32'(last_be), 32'h2);
`else
    chk("sb_wd", last_wd, 32'h1122AB44);
    chk("sb_be", 32'(last_be), 32'hF);
`endif

    run(1, 1, 32'h0000_3003, 32'h1234, 32'h0, 0, 0);
    run(0, 2, 32'h0000_5000, 32'h0, 32'h55AA55AA, 9, 0);
    chk("tmo_rdata", last_rdata, 32'h0);
    run(0, 2, 32'h0000_5004, 32'h0, 32'h0BADF00D, 0, 0);

    run(1, 1, 32'h0000_4002, 32'hBEEF, 32'hA5A5A5A5, 0, 0);
`ifdef BYTE_ENABLE_EN
    chk("sh_wd", last_wd, 32'hBEEFBEEF);
    chk("sh_be", 32'(last_be), 32'hC);
`else
    chk("sh_wd", last_wd, 32'hBEEFA5A5);
    chk("sh_be", 32'(last_be), 32'hF);
`endif

    run(1, 2, 32'h0000_6008, 32'hCAFEF00D, 32'h0, 0, 1);
    run(1, 0, 32'h0000_6000, 32'h77, 32'h01020304, 1, 2);
    run(1, 0, 32'h0000_6003, 32'h99, 32'h01020304, 0, 0);
    run(1, 1, 32'h0000_6010, 32'h5A5A, 32'hFFFFFFFF, 0, 3);
    run(0, 2, 32'h0000_7002, 32'h0, 32'h1, 0, 0);
    run(0, 1, 32'h0000_7001, 32'h0, 32'h2, 0, 0);
    run(0, 0, 32'h0000_7003, 32'h0, 32'h87654321, 3, 0);
    run(0, 3, 32'h0000_7008, 32'h0, 32'h13579BDF, 1, 0);
    run(1, 2, 32'h0000_700C, 32'h2468ACE0, 32'h0, 0, 3);
    run(1, 2, 32'h0000_7010, 32'h11111111, 32'h0, 0, 6);
    run(1, 0, 32'h0000_7014, 32'h22, 32'h33333333, 7, 0);
    run(1, 3, 32'h0000_7018, 32'h44444444, 32'h0, 0, 0);

    // async reset in the second stalled cycle of a write
    @(posedge clk); #1;
    req_valid = 1; req_write = 1; req_size = 2;
    req_addr = 32'h8000; req_wdata = 32'hFEEDFACE;
    @(posedge clk); #1;
    req_valid = 0; mem_waitrequest = 1;
    @(posedge clk); #1;
    chk("wr_before", {31'h0, mem_write}, 32'h1);
    reset = 1;
    #1;
    chk("wr_after", {31'h0, mem_write}, 32'h0);
    chk("stall_after", {31'h0, stall}, 32'h0);
    chk("addr_after", mem_address, 32'h0);
    @(negedge clk);
    reset = 0; mem_waitrequest = 0;
    run(0, 2, 32'h0000_9000, 32'h0, 32'hC0FFEE00, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequences one CPU load/store at a time onto the single-port data memory bus, which has a waitrequest handshake. Word loads and stores are single bus cycles. Sub-word stores (SB/SH) are done as read-modify-write on the aligned word. The block stalls the CPU until the access completes. It sits between the load/store datapath (address/op decode, load extraction) and the data RAM port.

Parameters:
TIMEOUT, 255, max consecutive waitrequest cycles per bus phase before abort with error; 0 = watchdog disabled
CNT_W, 16, width of watchdog counter; TIMEOUT must fit in CNT_W bits

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  CPU presents an access this cycle
req_write  in  1  1 = store, 0 = load
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = treated as word
req_addr  in  32  byte address (already base+offset)
req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
stall  out  1  CPU must hold its pipeline
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  32  raw aligned word read (loads); 0 for stores
rsp_err  out  1  valid with rsp_valid: misaligned access or timeout
mem_address  out  32  word-aligned bus address, {addr[31:2],2'b00}
mem_read  out  1  bus read strobe
mem_write  out  1  bus write strobe
mem_byteenable  out  4  lane k = bits [8k+7:8k]
mem_writedata  out  32  bus write data
mem_waitrequest  in  1  bus not ready; strobe and address must be held
mem_readdata  in  32  valid when mem_read=1 and mem_waitrequest=0

Behaviour:
- Reset (asynchronous): state IDLE, watchdog counter 0, latched request cleared. All outputs are 0, including any strobe that was mid-transfer.
- States: IDLE, READ, WRITE, DONE. Bus outputs are Moore outputs decoded from the state and the latched request.
- IDLE with req_valid=1: latch addr/size/write/wdata.
  - Misaligned access (half with addr[0]=1, word with addr[1:0]!=0) → DONE with err. No bus cycle is issued.
  - Load or sub-word store → READ.
  - Word store → WRITE.
- stall = (IDLE & req_valid) | READ | WRITE. stall is 0 in DONE, so the CPU advances on the rsp_valid cycle.
- READ: mem_read=1, mem_byteenable=4'hF. The block stays in READ while mem_waitrequest=1.
  - On waitrequest=0, capture mem_readdata.
  - Load → DONE with rsp_rdata = captured word.
  - Sub-word store → WRITE with merged word.
- Merge for byte store: lane addr[1:0] = req_wdata[7:0]; other lanes keep the read data.
- Merge for half store: offset 0 → lanes 1:0 = req_wdata[15:0]; offset 2 → lanes 3:2 = req_wdata[15:0].
- WRITE: mem_write=1, mem_byteenable=4'hF, mem_writedata = merged word (sub-word) or req_wdata (word). The block stays in WRITE while waitrequest=1, then goes to DONE.
- DONE: rsp_valid=1 for exactly one cycle → IDLE. rsp_rdata and rsp_err are valid only in DONE, 0 otherwise. A new request cannot be accepted in DONE. The earliest acceptance is the following IDLE cycle.
- Latency with zero waitrequest:
  - load or word store: 2 cycles from acceptance to rsp_valid
  - sub-word store: 3 cycles
  - misaligned access: 1 cycle
- Watchdog: the counter clears on entry to READ/WRITE and increments each cycle with waitrequest=1. When it reaches TIMEOUT (TIMEOUT≠0), drop the strobe and go to DONE with rsp_err=1 and rsp_rdata=0. On a timeout in the read phase, the write phase is skipped.
- mem_read and mem_write are never both 1.
- mem_address, byteenable and writedata are stable while waitrequest=1.
- req_* inputs are ignored outside IDLE.

Optional Feature:
BYTE_ENABLE_EN:
- Defined: sub-word stores skip READ and go IDLE→WRITE with mem_byteenable set to only the target lanes (byte: 1<<addr[1:0]; half: 4'b0011 or 4'b1100). The store data is replicated into those lanes (byte ×4, half ×2). Sub-word store latency becomes 2 cycles.
- Undefined: read-modify-write as above, with byteenable always 4'hF.

Test Plan:
- Word load, addr 0x0000_1004, mem_readdata 0xDEADBEEF, waitrequest high for 2 cycles → mem_address 0x1004 held for 3 cycles; rsp_valid in cycle 4 with rsp_rdata 0xDEADBEEF; stall high for cycles 0-3.
- SB addr 0x2001, wdata 0x000000AB, memory word 0x11223344 → read phase, then write of 0x1122AB44 with byteenable 4'hF; rsp_err=0.
- SH addr 0x3003 → no strobes; rsp_valid and rsp_err=1 one cycle after acceptance.
- TIMEOUT=4, LW with waitrequest stuck high → mem_read drops after 4 wait cycles; rsp_err=1, rsp_rdata=0; next request is accepted normally.
- Reset asserted in the second cycle of a stalled WRITE → mem_write=0 immediately (asynchronously); state IDLE; stall=0 once req_valid=0.
- With BYTE_ENABLE_EN, SH addr 0x4002, wdata 0x0000BEEF → single write, byteenable 4'b1100, writedata 0xBEEFBEEF; rsp_valid 2 cycles after acceptance.
